// File: rtl/fractal_pixel_scheduler.sv
// Raster-order pixel scheduler: hands (cr, ci, px, py) to a pool of escape-time cores, round-robin.
// Build option FRACTAL_SCHED_PERF_EN adds the perf_cycles[31:0] busy-cycle counter output.
module fractal_pixel_scheduler #(
  parameter int NUM_CORES   = 4,
  parameter int COORD_WIDTH = 32,
  parameter int DIM_WIDTH   = 12
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  input  logic                   cfg_start,
  input  logic                   cfg_abort,
  input  logic [DIM_WIDTH-1:0]   cfg_width,
  input  logic [DIM_WIDTH-1:0]   cfg_height,
  input  logic [COORD_WIDTH-1:0] cfg_x0,
  input  logic [COORD_WIDTH-1:0] cfg_y0,
  input  logic [COORD_WIDTH-1:0] cfg_dx,
  input  logic [COORD_WIDTH-1:0] cfg_dy,
  input  logic [NUM_CORES-1:0]   core_idle,
  output logic [NUM_CORES-1:0]   core_start,
  output logic [COORD_WIDTH-1:0] core_cr,
  output logic [COORD_WIDTH-1:0] core_ci,
  output logic [DIM_WIDTH-1:0]   core_px,
  output logic [DIM_WIDTH-1:0]   core_py,
  output logic                   busy,
  output logic                   frame_done
`ifdef FRACTAL_SCHED_PERF_EN
  ,
  output logic [31:0]            perf_cycles
`endif
);

  // state | meaning
  // IDLE  | waiting for cfg_start
  // RUN   | issuing pixels in raster order
  // DRAIN | no issues, waiting for every core to go idle
  // DONE  | one-cycle exit, frame_done/busy update on leaving
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [1:0]             state;
  logic [DIM_WIDTH-1:0]   width_q;
  logic [DIM_WIDTH-1:0]   height_q;
  logic [DIM_WIDTH-1:0]   x_q;
  logic [DIM_WIDTH-1:0]   y_q;
  logic [COORD_WIDTH-1:0] x0_q;
  logic [COORD_WIDTH-1:0] dx_q;
  logic [COORD_WIDTH-1:0] dy_q;
  logic [COORD_WIDTH-1:0] cr_q;
  logic [COORD_WIDTH-1:0] ci_q;
  logic [PTR_W-1:0]       rr_ptr;
  logic [NUM_CORES-1:0]   issued_last;

  logic [NUM_CORES-1:0]   eligible;
  logic [NUM_CORES-1:0]   grant_oh;
  logic [PTR_W-1:0]       grant_idx;
  logic                   grant_vld;
  logic                   issue;
  logic                   x_end;
  logic                   last_pixel;

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NUM_CORES) sum = sum - NUM_CORES;
    return PTR_W'(sum);
  endfunction

  // A core only lowers core_idle the cycle after its strobe, so last cycle's grant is masked out.
  always_comb begin
    logic [PTR_W-1:0] idx;
    eligible  = core_idle & ~issued_last;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = wrap_idx(rr_ptr, i);
      if (!grant_vld && eligible[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign issue      = (state == ST_RUN) && !cfg_abort && grant_vld;
  assign grant_oh   = issue ? (NUM_CORES'(1) << grant_idx) : '0;
  assign x_end      = (x_q == width_q - DIM_WIDTH'(1));
  assign last_pixel = x_end && (y_q == height_q - DIM_WIDTH'(1));

  assign core_start = grant_oh;
  assign core_cr    = cr_q;
  assign core_ci    = ci_q;
  assign core_px    = x_q;
  assign core_py    = y_q;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state       <= ST_IDLE;
      width_q     <= '0;
      height_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
      x0_q        <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      cr_q        <= '0;
      ci_q        <= '0;
      rr_ptr      <= '0;
      issued_last <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      issued_last <= grant_oh;
      frame_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            width_q  <= cfg_width;
            height_q <= cfg_height;
            x0_q     <= cfg_x0;
            dx_q     <= cfg_dx;
            dy_q     <= cfg_dy;
            x_q      <= '0;
            y_q      <= '0;
            cr_q     <= cfg_x0;
            ci_q     <= cfg_y0;
            busy     <= 1'b1;
            state    <= (cfg_width == '0 || cfg_height == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (cfg_abort) begin
            state <= ST_DRAIN;
          end else if (issue) begin
            rr_ptr <= wrap_idx(grant_idx, 1);
            if (x_end) begin
              x_q  <= '0;
              cr_q <= x0_q;
              y_q  <= y_q + DIM_WIDTH'(1);
              ci_q <= ci_q + dy_q;
            end else begin
              x_q  <= x_q + DIM_WIDTH'(1);
              cr_q <= cr_q + dx_q;
            end
            if (last_pixel) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((&core_idle) && (issued_last == '0)) state <= ST_DONE;
        end
        ST_DONE: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FRACTAL_SCHED_PERF_EN
  // Counts busy cycles of the current frame; holds afterwards until the next accepted start.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      perf_cycles <= '0;
    end else if (state == ST_IDLE && cfg_start) begin
      perf_cycles <= '0;
    end else if (busy && perf_cycles != '1) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fractal_pixel_scheduler.sv
// Randomized bench for fractal_pixel_scheduler against a raster/arithmetic reference model.
// Define FRACTAL_SCHED_PERF_EN for both bench and design to cover perf_cycles.
module tb_fractal_pixel_scheduler;
  localparam int N  = 4;
  localparam int CW = 32;
  localparam int DW = 12;
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_start = 1'b0, cfg_abort = 1'b0;
  logic [DW-1:0] cfg_width = '0, cfg_height = '0;
  logic [CW-1:0] cfg_x0 = '0, cfg_y0 = '0, cfg_dx = '0, cfg_dy = '0;
  logic [N-1:0]  core_idle = '0;
  logic [N-1:0]  core_start;
  logic [CW-1:0] core_cr, core_ci;
  logic [DW-1:0] core_px, core_py;
  logic          busy, frame_done;
`ifdef FRACTAL_SCHED_PERF_EN
  logic [31:0]   perf_cycles;
`endif

  always #5 clk = ~clk;

  fractal_pixel_scheduler #(.NUM_CORES(N), .COORD_WIDTH(CW), .DIM_WIDTH(DW)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_dx(cfg_dx), .cfg_dy(cfg_dy),
    .core_idle(core_idle), .core_start(core_start),
    .core_cr(core_cr), .core_ci(core_ci), .core_px(core_px), .core_py(core_py),
    .busy(busy), .frame_done(frame_done)
`ifdef FRACTAL_SCHED_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // core pool model
  int           rem[N];
  logic [N-1:0] en_mask = '1;
  logic [N-1:0] prev_start = '0;
  bit           const_idle = 1'b0;
  int           lat_min = 1, lat_max = 1;

  // reference model
  int            m_phase = P_IDLE;
  int            m_w, m_h, m_idx, m_total, m_rr, m_issued;
  logic [CW-1:0] m_x0, m_y0, m_dx, m_dy;
  logic [N-1:0]  m_last = '0;
  bit            m_busy = 1'b0, m_fd = 1'b0, fd_now = 1'b0;
  logic [31:0]   m_perf = '0;
  int            cyc = 0;

  // observed DUT activity for scenario-level checks
  int            dut_cores[$];
  int            dut_cycs[$];
  logic [CW-1:0] dut_cr[$];
  int            dut_fd[$];
  int            dut_busy_cnt;
  int            start_cyc;

  task automatic model_reset();
    m_phase = P_IDLE; m_rr = 0; m_last = '0; m_busy = 1'b0; m_fd = 1'b0;
    m_perf = '0; m_issued = 0; prev_start = '0; fd_now = 1'b0;
    for (int i = 0; i < N; i++) rem[i] = 0;
  endtask

  // One clock cycle: entered at posedge+1, checks at posedge+2, returns at next posedge+1.
  task automatic tick();
    logic [N-1:0]  exp_start;
    logic [CW-1:0] exp_cr, exp_ci;
    int            g, px, py, dut_idx;
    for (int i = 0; i < N; i++) begin
      if (rem[i] > 0) rem[i]--;
      if (prev_start[i]) rem[i] = $urandom_range(lat_max, lat_min);
      core_idle[i] = en_mask[i] && (const_idle || rem[i] == 0);
    end
    #1;
    exp_start = '0;
    g = -1;
    if (m_phase == P_RUN && !cfg_abort) begin
      for (int k = 0; k < N; k++) begin
        int c = (m_rr + k) % N;
        if (g < 0 && core_idle[c] && !m_last[c]) g = c;
      end
      if (g >= 0) exp_start[g] = 1'b1;
    end
    check_eq("core_start", 64'(core_start), 64'(exp_start));
    if (g >= 0) begin
      px     = m_idx % m_w;
      py     = m_idx / m_w;
      exp_cr = m_x0 + m_dx * CW'(px);
      exp_ci = m_y0 + m_dy * CW'(py);
      check_eq("core_px", 64'(core_px), 64'(px));
      check_eq("core_py", 64'(core_py), 64'(py));
      check_eq("core_cr", 64'(core_cr), 64'(exp_cr));
      check_eq("core_ci", 64'(core_ci), 64'(exp_ci));
    end
    check_eq("busy", 64'(busy), 64'(m_busy));
    check_eq("frame_done", 64'(frame_done), 64'(m_fd));
`ifdef FRACTAL_SCHED_PERF_EN
    check_eq("perf_cycles", 64'(perf_cycles), 64'(m_perf));
`endif
    if (core_start != '0) begin
      dut_idx = -1;
      for (int i = 0; i < N; i++) if (core_start[i]) dut_idx = i;
      dut_cores.push_back(dut_idx);
      dut_cycs.push_back(cyc);
      dut_cr.push_back(core_cr);
    end
    if (frame_done) dut_fd.push_back(cyc);
    if (busy) dut_busy_cnt++;
    fd_now = m_fd;

    // model advance across the coming edge
    if (m_busy && m_perf != '1) m_perf = m_perf + 32'd1;
    m_fd = 1'b0;
    case (m_phase)
      P_IDLE: if (cfg_start) begin
        m_w = int'(cfg_width); m_h = int'(cfg_height);
        m_x0 = cfg_x0; m_y0 = cfg_y0; m_dx = cfg_dx; m_dy = cfg_dy;
        m_idx = 0; m_total = m_w * m_h; m_issued = 0;
        m_busy = 1'b1; m_perf = '0;
        m_phase = (m_total == 0) ? P_DONE : P_RUN;
      end
      P_RUN: begin
        if (cfg_abort) m_phase = P_DRAIN;
        else if (g >= 0) begin
          m_idx++; m_issued++;
          m_rr = (g + 1) % N;
          if (m_idx == m_total) m_phase = P_DRAIN;
        end
      end
      P_DRAIN: if ((&core_idle) && m_last == '0) m_phase = P_DONE;
      default: begin
        m_fd = 1'b1; m_busy = 1'b0; m_phase = P_IDLE;
      end
    endcase
    m_last     = exp_start;
    prev_start = core_start;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int w, input int h, input logic [CW-1:0] x0, input logic [CW-1:0] y0,
                           input logic [CW-1:0] dx, input logic [CW-1:0] dy, input int abort_after,
                           input bit mid_start, input bit start_abort, input bit scramble);
    int budget;
    dut_cores.delete(); dut_cycs.delete(); dut_cr.delete(); dut_fd.delete();
    dut_busy_cnt = 0;
    cfg_width = DW'(w); cfg_height = DW'(h);
    cfg_x0 = x0; cfg_y0 = y0; cfg_dx = dx; cfg_dy = dy;
    cfg_start = 1'b1; cfg_abort = start_abort;
    start_cyc = cyc;
    tick();
    cfg_start = 1'b0; cfg_abort = 1'b0;
    if (scramble) begin
      cfg_width = DW'($urandom_range(9, 0)); cfg_height = DW'($urandom_range(9, 0));
      cfg_x0 = $urandom(); cfg_y0 = $urandom(); cfg_dx = $urandom(); cfg_dy = $urandom();
    end
    budget = 0;
    while (!fd_now && budget < 3000) begin
      if (m_phase != P_RUN) en_mask = '1;
      cfg_abort = (abort_after >= 0) && (m_issued >= abort_after) &&
                  (m_phase == P_RUN || m_phase == P_DRAIN);
      cfg_start = mid_start && (budget == 2);
      tick();
      budget++;
    end
    cfg_start = 1'b0; cfg_abort = 1'b0;
    check_eq("frame_bounded", 64'(budget < 3000), 64'(1));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_core_start", 64'(core_start), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_frame_done", 64'(frame_done), 64'(0));
    check_eq("rst_cr", 64'(core_cr), 64'(0));
    check_eq("rst_px", 64'(core_px), 64'(0));
    rst_n = 1'b1;
    repeat (2) tick();

    // 4x2 frame, every core permanently idle
    const_idle = 1'b1; en_mask = '1;
    run_frame(4, 2, 32'd0, 32'd0, 32'd1, 32'd16, -1, 1'b0, 1'b0, 1'b1);
    check_eq("t1_count", 64'(dut_cores.size()), 64'(8));
    for (int i = 0; i < dut_cores.size() && i < 8; i++) begin
      check_eq("t1_core", 64'(dut_cores[i]), 64'(i % 4));
      check_eq("t1_cycle", 64'(dut_cycs[i]), 64'(start_cyc + 1 + i));
    end
    check_eq("t1_done_cycle", 64'(dut_fd.size() > 0 ? dut_fd[0] : -1), 64'(start_cyc + 12));
`ifdef FRACTAL_SCHED_PERF_EN
    check_eq("t1_perf", 64'(perf_cycles), 64'(11));
`endif
    repeat (3) tick();
    const_idle = 1'b0;

    // only core 2 available, back idle 3 cycles after each issue
    lat_min = 2; lat_max = 2; en_mask = 4'b0100;
    run_frame(5, 2, 32'h100, 32'h200, 32'h3, 32'h5, -1, 1'b0, 1'b0, 1'b0);
    check_eq("t2_count", 64'(dut_cores.size()), 64'(10));
    for (int i = 0; i < dut_cores.size(); i++) begin
      check_eq("t2_core", 64'(dut_cores[i]), 64'(2));
      if (i > 0) check_eq("t2_spacing", 64'(dut_cycs[i] - dut_cycs[i-1]), 64'(3));
    end

    // empty frame
    en_mask = '1; lat_min = 1; lat_max = 3;
    run_frame(0, 5, 32'h1, 32'h1, 32'h1, 32'h1, -1, 1'b0, 1'b0, 1'b0);
    check_eq("t3_issues", 64'(dut_cores.size()), 64'(0));
    check_eq("t3_done_cycle", 64'(dut_fd.size() > 0 ? dut_fd[0] : -1), 64'(start_cyc + 2));
    check_eq("t3_busy_cycles", 64'(dut_busy_cnt), 64'(1));
`ifdef FRACTAL_SCHED_PERF_EN
    check_eq("t3_perf", 64'(perf_cycles), 64'(1));
`endif

    // 16x16 aborted after 5 issues, then a full frame
    lat_min = 1; lat_max = 3;
    run_frame(16, 16, $urandom(), $urandom(), $urandom(), $urandom(), 5, 1'b0, 1'b0, 1'b1);
    check_eq("t4_abort_count", 64'(dut_cores.size()), 64'(5));
    check_eq("t4_abort_done", 64'(dut_fd.size()), 64'(1));
    run_frame(16, 16, $urandom(), $urandom(), $urandom(), $urandom(), -1, 1'b0, 1'b0, 1'b1);
    check_eq("t4_full_count", 64'(dut_cores.size()), 64'(256));

    // coordinate wrap plus an ignored mid-frame start
    run_frame(2, 2, 32'h7FFF_FFFF, 32'h0, 32'h1, 32'h1, -1, 1'b1, 1'b0, 1'b0);
    check_eq("t5_count", 64'(dut_cores.size()), 64'(4));
    check_eq("t5_wrap_cr", 64'(dut_cr.size() > 1 ? dut_cr[1] : 32'h0), 64'(32'h8000_0000));

    // randomized frames: geometry, core availability, latency, abort, start+abort together
    for (int f = 0; f < 12; f++) begin
      int w, h, ab;
      w = $urandom_range(6, 1); h = $urandom_range(4, 1);
      ab = ($urandom_range(2, 0) == 0) ? $urandom_range(w * h, 0) : -1;
      en_mask = N'($urandom_range(15, 1));
      lat_min = 1; lat_max = $urandom_range(4, 1);
      run_frame(w, h, $urandom(), $urandom(), $urandom(), $urandom(), ab,
                1'b0, ($urandom_range(3, 0) == 0), 1'b1);
      repeat ($urandom_range(2, 0)) tick();
    end

    // async reset mid-frame clears everything at once
    en_mask = '1; lat_min = 1; lat_max = 2;
    cfg_width = 8; cfg_height = 8;
    cfg_x0 = 32'h1234_5678; cfg_y0 = 32'h0BAD_F00D; cfg_dx = 32'h11; cfg_dy = 32'h22;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_core_start", 64'(core_start), 64'(0));
    check_eq("rst_mid_busy", 64'(busy), 64'(0));
    check_eq("rst_mid_cr", 64'(core_cr), 64'(0));
    check_eq("rst_mid_ci", 64'(core_ci), 64'(0));
    check_eq("rst_mid_px", 64'(core_px), 64'(0));
`ifdef FRACTAL_SCHED_PERF_EN
    check_eq("rst_mid_perf", 64'(perf_cycles), 64'(0));
`endif
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dut_fd.delete();
    repeat (4) tick();
    check_eq("rst_mid_no_done", 64'(dut_fd.size()), 64'(0));
    run_frame(3, 3, 32'h10, 32'h20, 32'h1, 32'h2, -1, 1'b0, 1'b0, 1'b1);
    check_eq("post_rst_count", 64'(dut_cores.size()), 64'(9));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
